// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter with programmable modulus, prescaled enable,
// parallel load, synchronous clear, and registered STEP / TC (wrap) pulses.
module sync_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MOD_MAX  = 9,
   parameter int PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             UP,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] Q,
   output logic             STEP,
   output logic             TC
);

   localparam int               PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PCW-1:0]   PC_LAST = PCW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD_MAX);

   generate
      if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
         $error("sync_updown_counter: WIDTH must be 2..16");
      end
      if (MOD_MAX == 0 || MOD_MAX > (1 << WIDTH) - 1) begin : g_bad_mod
         $error("sync_updown_counter: MOD_MAX must be 1..2^WIDTH-1");
      end
      if (PRESCALE < 1 || PRESCALE > 1024) begin : g_bad_prescale
         $error("sync_updown_counter: PRESCALE must be 1..1024");
      end
   endgenerate

   // Out-of-range load values saturate to the top of the count range.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > Q_MAX) ? Q_MAX : v;
   endfunction

   function automatic logic wraps(input logic [WIDTH-1:0] q, input logic up);
      return up ? (q == Q_MAX) : (q == '0);
   endfunction

   function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] q, input logic up);
      if (up)
         return (q == Q_MAX) ? '0 : q + 1'b1;
      else
         return (q == '0) ? Q_MAX : q - 1'b1;
   endfunction

   logic [PCW-1:0] pc;
   logic           step_now;

   assign step_now = EN && (pc == PC_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q    <= '0;
         pc   <= '0;
         STEP <= 1'b0;
         TC   <= 1'b0;
      end else if (CLR) begin
         Q    <= '0;
         pc   <= '0;
         STEP <= 1'b0;
         TC   <= 1'b0;
      end else if (LOAD) begin
         Q    <= clamp_load(LOAD_VAL);
         pc   <= '0;
         STEP <= 1'b0;
         TC   <= 1'b0;
      end else if (step_now) begin
         Q    <= next_count(Q, UP);
         pc   <= '0;
         STEP <= 1'b1;
         TC   <= wraps(Q, UP);
      end else begin
         // EN low freezes the prescaler mid-count rather than restarting it.
         if (EN)
            pc <= pc + 1'b1;
         STEP <= 1'b0;
         TC   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter across three parameter sets.
module tb_sync_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A: WIDTH=4 MOD_MAX=9 PRESCALE=1
   logic       rst_a, en_a, up_a, clr_a, load_a;
   logic [3:0] lv_a, q_a;
   logic       step_a, tc_a;
   sync_updown_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1)) dut_a (
      .CLK(clk), .RST_N(rst_a), .EN(en_a), .UP(up_a), .CLR(clr_a), .LOAD(load_a),
      .LOAD_VAL(lv_a), .Q(q_a), .STEP(step_a), .TC(tc_a));

   // B: WIDTH=4 MOD_MAX=9 PRESCALE=4
   logic       rst_b, en_b, up_b, clr_b, load_b;
   logic [3:0] lv_b, q_b;
   logic       step_b, tc_b;
   sync_updown_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(4)) dut_b (
      .CLK(clk), .RST_N(rst_b), .EN(en_b), .UP(up_b), .CLR(clr_b), .LOAD(load_b),
      .LOAD_VAL(lv_b), .Q(q_b), .STEP(step_b), .TC(tc_b));

   // C: WIDTH=3 MOD_MAX=7 PRESCALE=1
   logic       rst_c, en_c, up_c, clr_c, load_c;
   logic [2:0] lv_c, q_c;
   logic       step_c, tc_c;
   sync_updown_counter #(.WIDTH(3), .MOD_MAX(7), .PRESCALE(1)) dut_c (
      .CLK(clk), .RST_N(rst_c), .EN(en_c), .UP(up_c), .CLR(clr_c), .LOAD(load_c),
      .LOAD_VAL(lv_c), .Q(q_c), .STEP(step_c), .TC(tc_c));

   int exp_dn [6] = '{9, 8, 7, 8, 9, 0};
   int exp_tc [6] = '{1, 0, 0, 0, 0, 1};

   initial begin
      rst_a = 1'b0; en_a = 1'b0; up_a = 1'b1; clr_a = 1'b0; load_a = 1'b0; lv_a = '0;
      rst_b = 1'b0; en_b = 1'b0; up_b = 1'b1; clr_b = 1'b0; load_b = 1'b0; lv_b = '0;
      rst_c = 1'b0; en_c = 1'b0; up_c = 1'b1; clr_c = 1'b0; load_c = 1'b0; lv_c = '0;
      tick();
      tick();
      chk("rst_q", int'(q_a), 0);
      chk("rst_step", int'(step_a), 0);
      chk("rst_tc", int'(tc_a), 0);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Plan 1: up count with wrap at 9
      en_a = 1'b1; up_a = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("up_q[%0d]", i), int'(q_a), i % 10);
         chk($sformatf("up_step[%0d]", i), int'(step_a), 1);
         chk($sformatf("up_tc[%0d]", i), int'(tc_a), (i % 10 == 0) ? 1 : 0);
      end

      // Plan 2: clear, count down through the wrap, then reverse
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("clr_q", int'(q_a), 0);
      chk("clr_step", int'(step_a), 0);
      up_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) up_a = 1'b1;
         tick();
         chk($sformatf("dn_q[%0d]", i), int'(q_a), exp_dn[i]);
         chk($sformatf("dn_tc[%0d]", i), int'(tc_a), exp_tc[i]);
      end

      // Plan 4: load, clamped load, clear beats load, hold when disabled
      en_a = 1'b0;
      load_a = 1'b1; lv_a = 4'd7;
      tick();
      chk("load7_q", int'(q_a), 7);
      chk("load7_tc", int'(tc_a), 0);
      chk("load7_step", int'(step_a), 0);
      lv_a = 4'd15;
      tick();
      chk("load15_q", int'(q_a), 9);
      clr_a = 1'b1; lv_a = 4'd5;
      tick();
      chk("clrload_q", int'(q_a), 0);
      clr_a = 1'b0; load_a = 1'b0;
      tick();
      chk("hold_q", int'(q_a), 0);
      chk("hold_step", int'(step_a), 0);

      // Plan 3: prescale by 4, then freeze the prescaler with EN low
      en_b = 1'b1; up_b = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("ps_q[%0d]", i), int'(q_b), i / 4);
         chk($sformatf("ps_step[%0d]", i), int'(step_b), (i % 4 == 0) ? 1 : 0);
      end
      tick();
      tick();
      chk("ps_pre_q", int'(q_b), 2);
      en_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("ps_frz_q[%0d]", i), int'(q_b), 2);
         chk($sformatf("ps_frz_step[%0d]", i), int'(step_b), 0);
      end
      en_b = 1'b1;
      tick();
      chk("ps_res1_q", int'(q_b), 2);
      chk("ps_res1_step", int'(step_b), 0);
      tick();
      chk("ps_res2_q", int'(q_b), 3);
      chk("ps_res2_step", int'(step_b), 1);

      // Plan 5: asynchronous reset mid-count
      for (int i = 0; i < 8; i++) tick();
      chk("pre_rst_q", int'(q_b), 5);
      chk("pre_rst_step", int'(step_b), 1);
      rst_b = 1'b0;
      #2;
      chk("arst_q", int'(q_b), 0);
      chk("arst_step", int'(step_b), 0);
      chk("arst_tc", int'(tc_b), 0);
      rst_b = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("post_rst_q[%0d]", i), int'(q_b), 0);
         chk($sformatf("post_rst_step[%0d]", i), int'(step_b), 0);
      end
      tick();
      chk("post_rst_q4", int'(q_b), 1);
      chk("post_rst_step4", int'(step_b), 1);

      // Plan 6: 3-bit natural binary wrap, both directions
      en_c = 1'b1; up_c = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk($sformatf("c_q[%0d]", i), int'(q_c), i % 8);
         chk($sformatf("c_tc[%0d]", i), int'(tc_c), (i % 8 == 0) ? 1 : 0);
      end
      up_c = 1'b0;
      tick();
      chk("c_dn_q", int'(q_c), 7);
      chk("c_dn_tc", int'(tc_c), 1);
      tick();
      chk("c_dn2_q", int'(q_c), 6);
      chk("c_dn2_tc", int'(tc_c), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
